fft_input_buffer_8point: RTL
============================

FFT_INPUT_BUFFER_8POINT -- requirements
Module: fft_input_buffer_8point

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of each real and imaginary sample.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port real_in, input, DATA_W bits, real part of the streamed sample.
REQ-005 The block SHALL have port imag_in, input, DATA_W bits, imaginary part of the streamed sample.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the upstream sample is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a sample.
REQ-008 The block SHALL have port real_out, output, array [0:7] of DATA_W bits, real parts of the presented frame.
REQ-009 The block SHALL have port imag_out, output, array [0:7] of DATA_W bits, imaginary parts of the presented frame.
REQ-010 The block SHALL have port frame_valid, output, 1 bit, meaning a complete 8-sample frame is presented.
REQ-011 The block SHALL have port frame_ready, input, 1 bit, meaning the downstream stage consumes the frame.
REQ-012 The block SHALL have port sample_cnt, output, 3 bits, giving the index of the next sample within the filling frame.

Function
REQ-013 The block SHALL hold two banks (0, 1), each of 8 complex entries, plus per-bank full flags, a write-bank pointer wbank and a read-bank pointer rbank.
REQ-014 The block SHALL drive in_ready = NOT full[wbank].
REQ-015 A sample SHALL be accepted in a cycle where in_valid and in_ready are both 1; it is stored into bank wbank at the entry address from REQ-027/028, then sample_cnt increments.
REQ-016 sample_cnt SHALL wrap from 7 to 0; on the accept with sample_cnt = 7, full[wbank] SHALL set and wbank SHALL toggle in the same edge.
REQ-017 The block SHALL drive frame_valid = full[rbank], with real_out/imag_out showing bank rbank, registered contents only, with no combinational path from real_in or imag_in.
REQ-018 frame_valid SHALL assert on the first rising edge after the 8th sample of a frame is accepted, giving a latency of 1 cycle, provided the other bank is not already presented.
REQ-019 A frame SHALL be consumed in a cycle where frame_valid and frame_ready are both 1; full[rbank] then clears and rbank toggles.
REQ-020 Once frame_valid is 1, the frame contents SHALL NOT change until consumed.
REQ-021 Frame completion and frame consumption in the same cycle SHALL both take effect, because they always target different banks; no sample or frame is lost.
REQ-022 With both banks full, in_ready SHALL be 0 and in_valid SHALL be ignored; after a consume, in_ready SHALL return to 1 on the next cycle.
REQ-023 Frames SHALL be delivered in arrival order, and with frame_ready held at 1 the block SHALL sustain 1 sample per cycle with no bubbles.

Reset
REQ-024 When rst is 1 at a rising edge, the block SHALL clear wbank, rbank, both full flags, sample_cnt and all bank entries to 0, regardless of any in-progress frame.
REQ-025 After reset the outputs SHALL read in_ready = 1, frame_valid = 0, sample_cnt = 0, real_out and imag_out all 0.
REQ-026 A partially filled frame SHALL be discarded by reset, and handshakes SHALL be ignored in the reset cycle.

Configuration
REQ-027 With macro BITREV_WRITE_EN defined, sample n SHALL be written to entry bitrev3(n), using the mapping 0,4,2,6,1,5,3,7, so real_out/imag_out present the frame already in bit-reversed order.
REQ-028 Without BITREV_WRITE_EN, sample n SHALL be written to entry n, giving natural order, for use with a separate bit-reversal stage.

Verification
REQ-029 Scenario: reset, then stream real 1..8 and imag 0, with frame_ready = 0 -> frame_valid = 1 one cycle after the 8th accept; without the macro real_out = 1,2,3,4,5,6,7,8; with the macro real_out = 1,5,3,7,2,6,4,8.
REQ-030 Scenario: frame_ready = 0 while streaming 16 samples (1..16) -> in_ready = 0 after the 16th accept, and sample 17 is not accepted; raising frame_ready presents 1..8 first, then 9..16.
REQ-031 Scenario: continuous in_valid = 1 and frame_ready = 1 for 64 cycles -> 8 frames delivered in order, in_ready never 0.
REQ-032 Scenario: the 8th sample of frame B is accepted in the same cycle frame A is consumed -> frame B is valid on the next cycle with correct data, and sample_cnt = 0.
REQ-033 Scenario: rst pulsed after 5 samples of a frame -> frame_valid = 0 and sample_cnt = 0; the next 8 samples form a clean frame containing none of the earlier 5.
REQ-034 Scenario: in_valid toggling every other cycle with values 0xFFFF / 0x8000 -> full-width values are stored unaltered, and sample_cnt advances only on accepted samples.

Source files
------------

// File: rtl/fft_input_buffer_8point.sv
// Ping-pong input buffer that gathers 8 streamed complex samples into a frame for an 8-point FFT.
// Define BITREV_WRITE_EN to store each frame in bit-reversed order instead of natural order.
module fft_input_buffer_8point #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] real_in,
  input  logic [DATA_W-1:0] imag_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] real_out [0:7],
  output logic [DATA_W-1:0] imag_out [0:7],
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [2:0]        sample_cnt
);

  logic [DATA_W-1:0] bank_re [2][8];
  logic [DATA_W-1:0] bank_im [2][8];
  logic [1:0]        full;
  logic              wbank;
  logic              rbank;
  logic [2:0]        waddr;
  logic              accept;
  logic              consume;

  assign in_ready    = ~full[wbank];
  assign frame_valid = full[rbank];
  assign accept      = in_valid & in_ready;
  assign consume     = frame_valid & frame_ready;

`ifdef BITREV_WRITE_EN
  assign waddr = {sample_cnt[0], sample_cnt[1], sample_cnt[2]};
`else
  assign waddr = sample_cnt;
`endif

  // Completion and consumption always hit different banks, so both may update full in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      full       <= '0;
      sample_cnt <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < 8; e++) begin
          bank_re[b][e] <= '0;
          bank_im[b][e] <= '0;
        end
      end
    end else begin
      if (accept) begin
        bank_re[wbank][waddr] <= real_in;
        bank_im[wbank][waddr] <= imag_in;
        sample_cnt            <= sample_cnt + 3'd1;
        if (sample_cnt == 3'd7) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      if (consume) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < 8; e++) begin
      real_out[e] = bank_re[rbank][e];
      imag_out[e] = bank_im[rbank][e];
    end
  end

endmodule
